// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, memory and cache-fill signal bundle for mem_arbiter.
//   master : arbiter side (takes cache requests and memory returns, drives memory
//            commands, fill writes, completion pulses and stall)
//   slave  : environment side (caches, pipeline and memory)
interface mem_arbiter_if;
    // Cache requests
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    // Memory command and return
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_vld;
    // Cache fill and completion
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        i_fill_we;
    logic        d_fill_we;
    logic        i_done;
    logic        d_done;
    logic        d_wr_ack;
    logic        stall;

    modport master (
        input  i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, mem_rdata, mem_vld,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_addr,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, stall
    );

    modport slave (
        output i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata, mem_rdata, mem_vld,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_addr,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined fixed-latency memory port between an I-cache
// (block fills) and a D-cache (block fills and single-word write-throughs).
// Ports:
//   clk   - system clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.master: requests, memory command/return, fill strobes,
//           done/ack pulses and pipeline stall
// Parameter WORDS: words per block (power of two, 2..8); block spans 2*WORDS bytes.
// Build option: define ARB_RR_FILL_EN to alternate simultaneous fill requests with a
// round-robin pointer; otherwise I-cache fills always beat D-cache fills.
// Write-throughs always take priority over fills.
module mem_arbiter #(
    parameter int unsigned WORDS = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int unsigned CntW     = $clog2(WORDS) + 1;
    localparam logic [15:0] BaseMask = ~(16'(2 * WORDS) - 16'd1);

    typedef enum logic [1:0] {StIdle, StWrite, StFillI, StFillD} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [15:0]       base_q, base_d;
    logic              grant_i, grant_d;
    logic              last_ret;
    logic              stall;

`ifdef ARB_RR_FILL_EN
    logic rr_q, rr_d;  // 0: I-cache preferred on the next contended fill

    assign grant_i = bus.i_req & (~bus.d_rd_req | ~rr_q);
    assign grant_d = bus.d_rd_req & ~grant_i;

    // Only contended fill grants move the pointer, so a lone requester cannot steal a turn.
    always_comb begin
        rr_d = rr_q;
        if (state_q == StIdle && !bus.d_wr_req && bus.i_req && bus.d_rd_req) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant_i = bus.i_req;
    assign grant_d = bus.d_rd_req & ~bus.i_req;
`endif

    assign last_ret = bus.mem_vld && (ret_cnt_q == CntW'(WORDS - 1));

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        base_d        = base_q;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 16'h0000;
        bus.fill_data = 16'h0000;
        bus.fill_addr = 16'h0000;
        bus.i_fill_we = 1'b0;
        bus.d_fill_we = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_done    = 1'b0;
        bus.d_wr_ack  = 1'b0;
        stall         = 1'b1;

        unique case (state_q)
            StIdle: begin
                stall = bus.i_req | bus.d_rd_req | bus.d_wr_req;
                if (bus.d_wr_req) begin
                    state_d = StWrite;
                end else if (grant_i) begin
                    state_d = StFillI;
                    base_d  = bus.i_addr & BaseMask;
                end else if (grant_d) begin
                    state_d = StFillD;
                    base_d  = bus.d_addr & BaseMask;
                end
            end
            StWrite: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_wr_ack  = 1'b1;
                stall         = bus.i_req | bus.d_rd_req;
                state_d       = StIdle;
            end
            StFillI, StFillD: begin
                // Reads are issued back to back; returns are counted independently.
                if (issue_cnt_q < CntW'(WORDS)) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q + (16'(issue_cnt_q) << 1);
                    issue_cnt_d  = issue_cnt_q + CntW'(1);
                end
                if (bus.mem_vld) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_addr = base_q + (16'(ret_cnt_q) << 1);
                    bus.i_fill_we = (state_q == StFillI);
                    bus.d_fill_we = (state_q == StFillD);
                    ret_cnt_d     = ret_cnt_q + CntW'(1);
                end
                if (last_ret) begin
                    bus.i_done  = (state_q == StFillI);
                    bus.d_done  = (state_q == StFillD);
                    state_d     = StIdle;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    // The finishing requester is not counted as pending.
                    stall = (state_q == StFillI) ? (bus.d_rd_req | bus.d_wr_req)
                                                 : (bus.i_req | bus.d_wr_req);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset must silence stall even while requests are held.
    assign bus.stall = rst_n & stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
        end
    end
endmodule
